rsa_msg_packer: RTL
===================

// Module: rsa_msg_packer
// PURPOSE
//   Upstream feeder for the RSA modular-exponentiation core. Accepts plaintext
//   as a byte stream (valid/ready), packs bytes MSB-first into 32-bit blocks,
//   pads the final short block and flags blocks >= modulus n. Presents each
//   block on a valid/ready output that drives the core's message input.
// PARAMETERS
//   PAD_BYTE   8'h00   fill byte for unused low-order bytes of the final block
//   IDX_W      16      width of the block index counter
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   n          in   32     RSA modulus, sampled on the cycle a block completes
//   s_data     in   8      plaintext byte
//   s_valid    in   1      s_data valid
//   s_last     in   1      s_data is the last byte of the message
//   s_ready    out  1      packer accepts a byte this cycle
//   m_block    out  32     packed block, first byte in [31:24]
//   m_valid    out  1      m_block valid
//   m_ready    in   1      consumer (RSA core) takes m_block this cycle
//   m_last     out  1      m_block is the final block of the message
//   m_pad      out  2      number of PAD_BYTE bytes in m_block (0..3)
//   m_oor      out  1      m_block >= n (or n == 0); block is not a valid residue
//   m_index    out  IDX_W  block index within message, 0-based
// BEHAVIOUR
//   Reset (async, any time): state=COLLECT; byte count=0; m_block=0; m_valid=0;
//     m_last=0; m_pad=0; m_oor=0; m_index=0; s_ready=1 after release. A partial
//     block in progress is discarded.
//   State COLLECT: s_ready=1, m_valid=0. Byte accepted when s_valid&&s_ready:
//     shift register <= {reg[23:0], s_data}; count++.
//     - 4th byte (count==3) and/or s_last: go to HOLD on the same edge.
//     - s_last with k bytes (k=1..3) held: block = data bytes in the top k byte
//       lanes, remaining 4-k low lanes = PAD_BYTE; m_pad=4-k; m_last=1.
//     - s_last on the 4th byte: m_pad=0, m_last=1.
//   State HOLD: m_valid=1, s_ready=0 (no byte accepted in HOLD).
//     m_block, m_last, m_pad, m_oor, m_index stable until m_valid&&m_ready.
//     On handshake: state=COLLECT, count=0, shift register cleared; m_index
//     increments, or returns to 0 if m_last was 1.
//   m_oor: registered on HOLD entry as (final block >= n) || (n == 0), unsigned
//     32-bit compare against n sampled that edge; n changes during HOLD do not
//     alter m_oor. Block is still presented; consumer decides to drop/reduce.
//   Latency: m_valid rises the cycle after the completing byte is accepted.
//     Peak throughput one block per 5 cycles (4 accepts + 1 handshake).
//   m_index wraps modulo 2^IDX_W without flagging.
//   s_valid low mid-block: count and register hold; no timeout.
//   s_last is ignored when s_valid is low.
// TESTING
//   1) n=32'hFFFFFFFF, bytes 01,02,03,04 (last on 04), m_ready=1 -> m_block=
//      32'h01020304, m_valid 1 cycle after byte 04, m_last=1, m_pad=0, m_oor=0.
//   2) Bytes AA,BB with last on BB, PAD_BYTE=00 -> m_block=32'hAABB0000,
//      m_pad=2, m_last=1; next message's first block has m_index=0.
//   3) 8 bytes 11..18, m_ready low 5 cycles on block 0 -> m_block stays
//      32'h11121314, s_ready=0 throughout; block 1=32'h15161718, m_index=1.
//   4) n=32'hC0000001, block FF,FF,FF,FF -> m_oor=1; block 12,34,56,78 -> m_oor=0;
//      n=0 with any block -> m_oor=1; block equal to n -> m_oor=1.
//   5) Assert reset after 2 bytes of a block, release, send 4 bytes A1..A4 ->
//      m_block=32'hA1A2A3A4, m_index=0; all outputs 0 during reset.
//   6) Single byte 7F with last, PAD_BYTE=8'hFF -> m_block=32'h7FFFFFFF, m_pad=3.

Source files
------------

// File: rtl/rsa_msg_packer.sv
// rsa_msg_packer: packs a plaintext byte stream MSB-first into padded 32-bit blocks for the RSA core
module rsa_msg_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         IDX_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [31:0]      m_block,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [1:0]       m_pad,
    output logic             m_oor,
    output logic [IDX_W-1:0] m_index
);
    typedef enum logic {COLLECT, HOLD} state_t;
    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d, pad_q, pad_d;
    logic [23:0] sh_q, sh_d;
    logic [31:0] blk_q, blk_d, word, packed_blk;
    logic last_q, last_d, oor_q, oor_d, acc, done, hs;
    logic [IDX_W-1:0] idx_q, idx_d;
    assign s_ready = state_q == COLLECT && !reset;
    assign m_valid = state_q == HOLD;
    assign m_block = blk_q;
    assign m_last  = last_q;
    assign m_pad   = pad_q;
    assign m_oor   = oor_q;
    assign m_index = idx_q;
    assign acc  = s_valid && s_ready;
    assign done = acc && (cnt_q == 2'd3 || s_last);
    assign hs   = m_valid && m_ready;
    assign word = {sh_q, s_data};
    // bytes collected so far sit in the low lanes; left-justify and fill the rest with padding
    assign packed_blk = cnt_q == 2'd3 ? word :
                        cnt_q == 2'd2 ? {word[23:0], PAD_BYTE} :
                        cnt_q == 2'd1 ? {word[15:0], {2{PAD_BYTE}}} :
                                        {word[7:0], {3{PAD_BYTE}}};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        blk_d   = blk_q;
        last_d  = last_q;
        pad_d   = pad_q;
        oor_d   = oor_q;
        idx_d   = idx_q;
        if (acc) begin
            sh_d  = {sh_q[15:0], s_data};
            cnt_d = cnt_q + 2'd1;
        end
        if (done) begin
            state_d = HOLD;
            blk_d   = packed_blk;
            last_d  = s_last;
            pad_d   = 2'd3 - cnt_q;
            oor_d   = packed_blk >= n || n == 32'd0;
        end
        if (hs) begin
            state_d = COLLECT;
            cnt_d   = 2'd0;
            sh_d    = 24'd0;
            idx_d   = last_q ? '0 : idx_q + IDX_W'(1);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            cnt_q   <= 2'd0;
            sh_q    <= 24'd0;
            blk_q   <= 32'd0;
            last_q  <= 1'b0;
            pad_q   <= 2'd0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
            oor_q   <= oor_d;
            idx_q   <= idx_d;
        end
    end
endmodule
